reg_dump_engine: RTL and testbench

- Parametrised register-file dump engine for the CPU core.
- On a halt rising edge, or on an explicit request, it walks every architectural register through a combinational read port.
- Each register is streamed out as a valid/ready word stream, tagged with its index and a last flag.
- Replaces the simulation-only register printout with synthesisable hardware that feeds the output port, UART or debug logic.

---
 rtl/cpu_debug_pkg.sv | 15 +
 rtl/rise_edge_detect.sv | 22 ++
 rtl/reg_dump_engine.sv | 118 +++++++++++
 tb/tb_reg_dump_engine.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_debug_pkg.sv
// Shared CPU debug definitions: dump FSM states, dump counter width and the
// register-file geometry defaults shared with the register file.
package cpu_debug_pkg;

  localparam int unsigned DUMP_CNT_W  = 8;
  localparam int unsigned RF_DATA_W   = 8;
  localparam int unsigned RF_NUM_REGS = 8;

  typedef enum logic [1:0] {
    DUMP_IDLE,
    DUMP_LOAD,
    DUMP_SEND
  } dump_state_e;

endpackage

// File: rtl/rise_edge_detect.sv
// Level-to-pulse converter: registers the level and flags a 0->1 transition
// in the same cycle the level rises.
module rise_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise_c
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign rise_c = level & ~level_q;

endmodule

// File: rtl/reg_dump_engine.sv
// Register-file dump engine: on a halt rising edge or an explicit request,
// streams every register out as an indexed valid/ready word stream.
module reg_dump_engine
  import cpu_debug_pkg::*;
#(
  parameter int unsigned DATA_W       = RF_DATA_W,
  parameter int unsigned NUM_REGS     = RF_NUM_REGS,
  parameter int unsigned IDX_W        = $clog2(NUM_REGS),
  parameter bit          AUTO_ON_HALT = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  halt,
  input  logic                  dump_req,
  output logic [IDX_W-1:0]      rf_raddr,
  input  logic [DATA_W-1:0]     rf_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [DUMP_CNT_W-1:0] dump_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  dump_state_e           state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic                  valid_d, last_d, busy_d, done_d;
  logic [DATA_W-1:0]     data_d;
  logic [IDX_W-1:0]      idx_d;
  logic [DUMP_CNT_W-1:0] cnt_d;
  logic                  halt_rise_c;
  logic                  trig_c;

  rise_edge_detect u_halt_edge (
    .clk    (clk),
    .reset  (reset),
    .level  (halt),
    .rise_c (halt_rise_c)
  );

  assign trig_c   = dump_req | (AUTO_ON_HALT & halt_rise_c);
  assign rf_raddr = ptr_q;

  // Next-state and datapath; triggers outside IDLE are simply dropped
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = out_valid;
    data_d  = out_data;
    idx_d   = out_idx;
    last_d  = out_last;
    busy_d  = busy;
    done_d  = 1'b0;
    cnt_d   = dump_count;
    case (state_q)
      DUMP_IDLE: begin
        if (trig_c) begin
          ptr_d   = '0;
          busy_d  = 1'b1;
          state_d = DUMP_LOAD;
        end
      end
      DUMP_LOAD: begin
        data_d  = rf_rdata;
        idx_d   = ptr_q;
        last_d  = (ptr_q == LAST_IDX);
        valid_d = 1'b1;
        state_d = DUMP_SEND;
      end
      DUMP_SEND: begin
        if (out_valid && out_ready) begin
          valid_d = 1'b0;
          if (out_last) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = dump_count + DUMP_CNT_W'(1);
            state_d = DUMP_IDLE;
          end else begin
            ptr_d   = ptr_q + IDX_W'(1);
            state_d = DUMP_LOAD;
          end
        end
      end
      default: begin
        state_d = DUMP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= DUMP_IDLE;
      ptr_q      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_idx    <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dump_count <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      out_valid  <= valid_d;
      out_data   <= data_d;
      out_idx    <= idx_d;
      out_last   <= last_d;
      busy       <= busy_d;
      done       <= done_d;
      dump_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_reg_dump_engine.sv
// Bench for reg_dump_engine: a default 8x8-bit instance and a 5x16-bit
// request-only instance, checked against a word-queue reference model.
module tb_reg_dump_engine;

  typedef struct {
    logic        last;
    logic [2:0]  idx;
    logic [15:0] data;
  } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, halt, dump_req, out_ready;
  logic cfg;
  logic [15:0] rf [8];

  logic [2:0]  a_raddr, a_idx;
  logic [7:0]  a_rdata, a_data, a_cnt;
  logic        a_valid, a_last, a_busy, a_done;
  logic [2:0]  b_raddr, b_idx;
  logic [15:0] b_rdata, b_data;
  logic [7:0]  b_cnt;
  logic        b_valid, b_last, b_busy, b_done;

  logic a_halt, a_req, a_ready, b_halt, b_req, b_ready;
  assign a_halt  = halt & ~cfg;
  assign a_req   = dump_req & ~cfg;
  assign a_ready = out_ready & ~cfg;
  assign b_halt  = halt & cfg;
  assign b_req   = dump_req & cfg;
  assign b_ready = out_ready & cfg;
  assign a_rdata = rf[a_raddr][7:0];
  assign b_rdata = rf[b_raddr];

  reg_dump_engine u_a (
    .clk(clk), .reset(reset), .halt(a_halt), .dump_req(a_req),
    .rf_raddr(a_raddr), .rf_rdata(a_rdata),
    .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data),
    .out_idx(a_idx), .out_last(a_last), .busy(a_busy), .done(a_done),
    .dump_count(a_cnt)
  );

  reg_dump_engine #(.DATA_W(16), .NUM_REGS(5), .AUTO_ON_HALT(1'b0)) u_b (
    .clk(clk), .reset(reset), .halt(b_halt), .dump_req(b_req),
    .rf_raddr(b_raddr), .rf_rdata(b_rdata),
    .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data),
    .out_idx(b_idx), .out_last(b_last), .busy(b_busy), .done(b_done),
    .dump_count(b_cnt)
  );

  // Outputs of whichever instance is currently being exercised
  logic        o_valid, o_last, o_busy, o_done;
  logic [15:0] o_data;
  logic [2:0]  o_idx, o_raddr;
  logic [7:0]  o_cnt;
  always_comb begin
    o_valid = cfg ? b_valid : a_valid;
    o_last  = cfg ? b_last  : a_last;
    o_busy  = cfg ? b_busy  : a_busy;
    o_done  = cfg ? b_done  : a_done;
    o_data  = cfg ? b_data  : {8'h00, a_data};
    o_idx   = cfg ? b_idx   : a_idx;
    o_raddr = cfg ? b_raddr : a_raddr;
    o_cnt   = cfg ? b_cnt   : a_cnt;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a dump is a queue of NUM_REGS expected words
  logic        m_started = 1'b0;
  logic        m_busy, m_done, m_halt_q, m_after_rst, m_stall, m_first, m_allrdy;
  logic [7:0]  m_cnt [2];
  logic [15:0] m_pdata;
  logic [2:0]  m_pidx;
  int          m_lat, m_blen;
  word_t       exp_q[$];

  always @(negedge clk) begin
    int          n;
    logic        trig, was_busy;
    logic [15:0] mask;
    word_t       w;
    n    = cfg ? 5 : 8;
    mask = cfg ? 16'hffff : 16'h00ff;
    if (m_started) begin
      check("busy", 32'(o_busy), 32'(m_busy));
      check("done", 32'(o_done), 32'(m_done));
      check("dump_count", 32'(o_cnt), 32'(m_cnt[cfg]));
      check("raddr_range", 32'(32'(o_raddr) < n), 32'd1);
      check("valid_when_idle", 32'(o_valid & ~m_busy), 32'd0);
      if (m_after_rst) begin
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_idx", 32'(o_idx), 32'd0);
        check("rst_last", 32'(o_last), 32'd0);
        check("rst_raddr", 32'(o_raddr), 32'd0);
      end
      if (m_stall) begin
        check("hold_valid", 32'(o_valid), 32'd1);
        check("hold_data", 32'(o_data), 32'(m_pdata));
        check("hold_idx", 32'(o_idx), 32'(m_pidx));
      end
      if (o_busy) m_blen++;
      if (m_first && m_busy) begin
        m_lat++;
        if (o_valid) begin
          check("first_latency", 32'(m_lat), 32'd2);
          m_first = 1'b0;
        end
      end
    end
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_halt_q = 1'b0; m_stall = 1'b0;
      m_first = 1'b0; m_cnt[0] = 8'd0; m_cnt[1] = 8'd0;
      exp_q.delete();
      m_after_rst = 1'b1;
      m_started   = 1'b1;
    end else begin
      was_busy    = m_busy;
      m_after_rst = 1'b0;
      m_done      = 1'b0;
      if (o_valid && !out_ready) m_allrdy = 1'b0;
      if (o_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 32'd1, 32'd0);
        end else begin
          w = exp_q.pop_front();
          check("word_idx", 32'(o_idx), 32'(w.idx));
          check("word_data", 32'(o_data), 32'(w.data));
          check("word_last", 32'(o_last), 32'(w.last));
          if (exp_q.size() == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_cnt[cfg] = m_cnt[cfg] + 8'd1;
            if (m_allrdy) check("busy_cycles", 32'(m_blen), 32'(2 * n));
          end
        end
      end
      trig = dump_req | (~cfg & halt & ~m_halt_q);
      if (trig && !was_busy) begin
        m_busy = 1'b1; m_first = 1'b1; m_lat = 0; m_blen = 0; m_allrdy = 1'b1;
        for (int i = 0; i < n; i++) begin
          w.last = (i == n - 1);
          w.idx  = 3'(i);
          w.data = rf[i] & mask;
          exp_q.push_back(w);
        end
      end
      m_halt_q = halt;
      m_stall  = o_valid & ~out_ready;
      m_pdata  = o_data;
      m_pidx   = o_idx;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (o_done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) check("timeout_done", 32'd0, 32'd1);
  endtask

  task automatic wait_word(input logic [2:0] idx, input int budget);
    int k;
    k = 0;
    while (!(o_valid === 1'b1 && o_idx == idx) && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) check("timeout_word", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; dump_req = 1'b0; out_ready = 1'b1; cfg = 1'b0;
    for (int i = 0; i < 8; i++) rf[i] = 16'h10 + 16'(i);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Halt rising edge, ready held high
    halt = 1'b1;
    tick();
    wait_done(100);
    check("t1_count", 32'(o_cnt), 32'd1);
    halt = 1'b0;
    repeat (2) tick();

    // Backpressure on idx 3
    pulse_req();
    wait_word(3'd3, 100);
    out_ready = 1'b0;
    repeat (5) begin
      check("bp_data", 32'(o_data), 32'h13);
      check("bp_idx", 32'(o_idx), 32'd3);
      tick();
    end
    out_ready = 1'b1;
    wait_done(100);
    check("t2_count", 32'(o_cnt), 32'd2);
    repeat (2) tick();

    // Held halt plus requests while busy give a single dump
    halt = 1'b1;
    tick();
    repeat (3) begin
      repeat (3) tick();
      pulse_req();
    end
    wait_done(100);
    repeat (10) tick();
    check("held_busy", 32'(o_busy), 32'd0);
    check("held_count", 32'(o_cnt), 32'd3);
    halt = 1'b0;
    tick();

    // Request in the done cycle starts the next dump immediately
    pulse_req();
    wait_done(100);
    pulse_req();
    check("b2b_busy", 32'(o_busy), 32'd1);
    wait_done(100);
    check("b2b_count", 32'(o_cnt), 32'd5);
    repeat (2) tick();

    // Reset in the middle of a dump
    pulse_req();
    wait_word(3'd2, 100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_done", 32'(o_done), 32'd0);
    check("mid_rst_count", 32'(o_cnt), 32'd0);
    repeat (3) tick();
    pulse_req();
    wait_done(100);
    check("post_rst_count", 32'(o_cnt), 32'd1);
    repeat (2) tick();

    // Request-only 5x16-bit instance ignores halt
    cfg = 1'b1;
    for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
    tick();
    halt = 1'b1;
    repeat (10) tick();
    check("noauto_busy", 32'(o_busy), 32'd0);
    halt = 1'b0;
    tick();
    pulse_req();
    wait_done(100);
    check("b_count", 32'(o_cnt), 32'd1);
    repeat (2) tick();
    cfg = 1'b0;
    tick();

    // Random traffic; long enough to wrap dump_count
    for (int c = 0; c < 12000; c++) begin
      out_ready = ($urandom_range(9) < 7);
      dump_req  = ($urandom_range(24) == 0);
      if ($urandom_range(11) == 0) halt = ~halt;
      if (!o_busy && $urandom_range(3) == 0)
        for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
      tick();
    end
    dump_req = 1'b0; halt = 1'b0; out_ready = 1'b1;
    tick();
    if (o_busy) wait_done(100);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
